// File: rtl/llm_ctrl_pkg.sv
// Shared definitions for the language-model controller slice: engine-arbiter
// states, default sizing and the fixed requester indices.
package llm_ctrl_pkg;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 12;

    localparam int REQ_PROJ      = 0;
    localparam int REQ_QK_MATMUL = 1;
    localparam int REQ_LINEAR1   = 2;
    localparam int REQ_LINEAR2   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr,
// returned one-hot (all-zero when nothing is requested).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick
);

    logic [NREQ-1:0] pick_s;
    logic            found_s;
    logic [PW-1:0]   idx_s;

    // Scan requesters starting at ptr and keep the first hit.
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = PW'((int'(ptr) + i) % NREQ);
            if (!found_s && req[idx_s]) begin
                pick_s[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign pick = pick_s;

endmodule

// File: rtl/linear_engine_arb.sv
// Round-robin arbiter sharing one linear-algebra engine between requesters:
// latches the winner's job descriptor, launches the engine and guards it with a watchdog.
module linear_engine_arb #(
    parameter int NREQ    = llm_ctrl_pkg::NREQ,
    parameter int AW      = llm_ctrl_pkg::AW,
    parameter int DW      = llm_ctrl_pkg::DW,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*AW-1:0] cfg_src,
    input  logic [NREQ*AW-1:0] cfg_dst,
    input  logic [NREQ*DW-1:0] cfg_rows,
    input  logic [NREQ*DW-1:0] cfg_cols,
    input  logic             eng_done,
    output logic             eng_start,
    output logic [AW-1:0]    eng_src,
    output logic [AW-1:0]    eng_dst,
    output logic [DW-1:0]    eng_rows,
    output logic [DW-1:0]    eng_cols,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic             err
);
    import llm_ctrl_pkg::*;

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW:0] TIMEOUT_V = (WDW+1)'(TIMEOUT);

    arb_state_t      state_r, state_s;
    logic [PW-1:0]   ptr_r, ptr_s, win_r, win_s, pick_idx_s;
    logic [NREQ-1:0] grant_r, grant_s, done_r, done_s, pick_s;
    logic            start_r, start_s, err_r, err_s, busy_r, busy_s;
    logic [AW-1:0]   src_r, src_s, dst_r, dst_s;
    logic [DW-1:0]   rows_r, rows_s, cols_r, cols_s;
    logic [WDW-1:0]  wd_r, wd_s;

    logic [AW-1:0] src_a  [NREQ];
    logic [AW-1:0] dst_a  [NREQ];
    logic [DW-1:0] rows_a [NREQ];
    logic [DW-1:0] cols_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign src_a[g]  = cfg_src[g*AW +: AW];
        assign dst_a[g]  = cfg_dst[g*AW +: AW];
        assign rows_a[g] = cfg_rows[g*DW +: DW];
        assign cols_a[g] = cfg_cols[g*DW +: DW];
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req  (req),
        .ptr  (ptr_r),
        .pick (pick_s)
    );

    // Encode the one-hot pick so the winner's descriptor can be selected.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_s[i]) begin
                pick_idx_s = PW'(i);
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Next-state and next-output logic of the arbitration sequence.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        grant_s = grant_r;
        done_s  = '0;
        start_s = 1'b0;
        src_s   = src_r;
        dst_s   = dst_r;
        rows_s  = rows_r;
        cols_s  = cols_r;
        wd_s    = wd_r;
        // A completion outside RUN never sequences the FSM, only flags it.
        err_s   = err_r | (eng_done & (state_r != ST_RUN));
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s = ST_ISSUE;
                    grant_s = pick_s;
                    win_s   = pick_idx_s;
                    start_s = 1'b1;
                    src_s   = src_a[pick_idx_s];
                    dst_s   = dst_a[pick_idx_s];
                    rows_s  = rows_a[pick_idx_s];
                    cols_s  = cols_a[pick_idx_s];
                end else begin
                    grant_s = '0;
                end
            end
            ST_ISSUE: begin
                state_s = ST_RUN;
                wd_s    = '0;
            end
            ST_RUN: begin
                if (eng_done) begin
                    state_s = ST_RELEASE;
                    done_s  = grant_r;
                end else if (({1'b0, wd_r} + (WDW+1)'(1)) == TIMEOUT_V) begin
                    // Watchdog: release the owner anyway so it cannot deadlock.
                    state_s = ST_RELEASE;
                    done_s  = grant_r;
                    err_s   = 1'b1;
                end else begin
                    wd_s = wd_r + WDW'(1);
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
                grant_s = '0;
                ptr_s   = (win_r == PW'(NREQ - 1)) ? '0 : win_r + PW'(1);
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            grant_r <= '0;
            done_r  <= '0;
            start_r <= 1'b0;
            src_r   <= '0;
            dst_r   <= '0;
            rows_r  <= '0;
            cols_r  <= '0;
            wd_r    <= '0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            start_r <= start_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            rows_r  <= rows_s;
            cols_r  <= cols_s;
            wd_r    <= wd_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
        end
    end

    assign eng_start = start_r;
    assign eng_src   = src_r;
    assign eng_dst   = dst_r;
    assign eng_rows  = rows_r;
    assign eng_cols  = cols_r;
    assign grant     = grant_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: tb/tb_linear_engine_arb.sv
// Self-checking bench for linear_engine_arb: directed scenarios plus randomized
// jobs checked against a round-robin reference model.
module tb_linear_engine_arb;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] cfg_src = '0, cfg_dst = '0;
    logic [NREQ*DW-1:0] cfg_rows = '0, cfg_cols = '0;
    logic eng_done = 1'b0, wd_eng_done = 1'b0;

    logic eng_start, busy, err;
    logic [AW-1:0] eng_src, eng_dst;
    logic [DW-1:0] eng_rows, eng_cols;
    logic [NREQ-1:0] grant, done;

    logic wd_start, wd_busy, wd_err;
    logic [AW-1:0] wd_src, wd_dst;
    logic [DW-1:0] wd_rows, wd_cols;
    logic [NREQ-1:0] wd_grant, wd_done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int m_ptr = 0;

    linear_engine_arb dut (
        .clk(clk), .reset(reset), .req(req),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .eng_done(eng_done), .eng_start(eng_start),
        .eng_src(eng_src), .eng_dst(eng_dst), .eng_rows(eng_rows), .eng_cols(eng_cols),
        .grant(grant), .done(done), .busy(busy), .err(err)
    );

    linear_engine_arb #(.TIMEOUT(8)) dut_wd (
        .clk(clk), .reset(reset), .req(req),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .eng_done(wd_eng_done), .eng_start(wd_start),
        .eng_src(wd_src), .eng_dst(wd_dst), .eng_rows(wd_rows), .eng_cols(wd_cols),
        .grant(wd_grant), .done(wd_done), .busy(wd_busy), .err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at or after ptr, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        eng_done = 1'b0;
        tick();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic randomize_cfg();
        cfg_src  = {$urandom(), $urandom()};
        cfg_dst  = {$urandom(), $urandom()};
        cfg_rows = 48'({$urandom(), $urandom()});
        cfg_cols = 48'({$urandom(), $urandom()});
    endtask

    // One complete job from an IDLE cycle with req already applied.
    task automatic do_job(input int lat, input bit perturb);
        int w;
        logic [NREQ-1:0] g;
        logic [AW-1:0] s_src, s_dst;
        logic [DW-1:0] s_rows, s_cols;
        w = model_pick(req, m_ptr);
        g = NREQ'(1) << w;
        s_src  = cfg_src[w*AW +: AW];
        s_dst  = cfg_dst[w*AW +: AW];
        s_rows = cfg_rows[w*DW +: DW];
        s_cols = cfg_cols[w*DW +: DW];
        tick();
        check("issue_grant", 64'(grant), 64'(g));
        check("issue_start", 64'(eng_start), 64'(1));
        check("issue_busy", 64'(busy), 64'(1));
        check("issue_desc", 64'({eng_src, eng_dst, eng_rows, eng_cols}),
              64'({s_src, s_dst, s_rows, s_cols}));
        if (perturb) begin
            randomize_cfg();
            req = req & 4'($urandom());
        end
        repeat (lat) begin
            tick();
            check("run_start", 64'(eng_start), 64'(0));
            check("run_grant", 64'(grant), 64'(g));
            check("run_done", 64'(done), 64'(0));
            check("run_desc", 64'({eng_src, eng_dst, eng_rows, eng_cols}),
                  64'({s_src, s_dst, s_rows, s_cols}));
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("rel_done", 64'(done), 64'(g));
        check("rel_grant", 64'(grant), 64'(g));
        tick();
        check("idle_grant", 64'(grant), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        m_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_outs", 64'({grant, done, eng_start, busy, err}), 64'(0));
        check("rst_desc", 64'({eng_src, eng_dst, eng_rows, eng_cols}), 64'(0));
        check("rst_wd_outs", 64'({wd_grant, wd_done, wd_start, wd_busy, wd_err}), 64'(0));
        check("rst_wd_desc", 64'({wd_src, wd_dst, wd_rows, wd_cols}), 64'(0));
        reset = 1'b0;

        // Single request with exact latencies
        randomize_cfg();
        cfg_src[2*AW +: AW] = 16'h1200;
        req = 4'b0100;
        tick();
        check("single_grant", 64'(grant), 64'(4'b0100));
        check("single_start", 64'(eng_start), 64'(1));
        check("single_src", 64'(eng_src), 64'(16'h1200));
        repeat (9) begin
            tick();
            check("single_wait_done", 64'(done), 64'(0));
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        req = '0;
        check("single_done", 64'(done), 64'(4'b0100));
        tick();
        check("single_grant_off", 64'(grant), 64'(0));
        check("single_done_off", 64'(done), 64'(0));

        // Fairness with all four requesters held high
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) do_job(2, 1'b0);
        req = '0;

        // Stale request from requester 0 loses to requester 3
        do_reset();
        req = 4'b0001;
        do_job(1, 1'b0);
        req = 4'b1001;
        do_job(1, 1'b0);
        req = '0;

        // Spurious completion in IDLE
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("spur_err", 64'(err), 64'(1));
        check("spur_grant", 64'(grant), 64'(0));
        check("spur_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        check("spur_err_sticky", 64'(err), 64'(1));
        req = 4'b0010;
        do_job(2, 1'b0);
        req = '0;
        check("spur_err_after_job", 64'(err), 64'(1));

        // Reset mid-job abandons it and clears err
        req = 4'b0100;
        tick();
        tick();
        check("midrst_busy_before", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = '0;
        check("midrst_outs", 64'({busy, grant, done, eng_start, err}), 64'(0));
        tick();
        check("midrst_no_done", 64'({done, busy}), 64'(0));
        m_ptr = 0;

        // Watchdog on the TIMEOUT=8 instance
        do_reset();
        req = 4'b0010;
        tick();
        check("wd_start", 64'(wd_start), 64'(1));
        check("wd_grant", 64'(wd_grant), 64'(4'b0010));
        req = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("wd_early", 64'({wd_done, wd_err}), 64'(0));
        end
        tick();
        check("wd_done", 64'(wd_done), 64'(4'b0010));
        check("wd_err", 64'(wd_err), 64'(1));
        tick();
        check("wd_grant_off", 64'({wd_grant, wd_busy}), 64'(0));

        // Randomized jobs against the reference model
        do_reset();
        for (int n = 0; n < 24; n++) begin
            randomize_cfg();
            req = 4'($urandom_range(1, 15));
            do_job(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        end
        req = '0;
        check("rand_no_err", 64'(err), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/linear_engine_arb.md
LINEAR_ENGINE_ARB -- requirements
Module: linear_engine_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the requester count (0=proj, 1=qk_matmul, 2=linear1, 3=linear2).
REQ-002 Parameter AW, default 16, SHALL set the engine SRAM address width.
REQ-003 Parameter DW, default 12, SHALL set the rows/cols dimension width.
REQ-004 Parameter TIMEOUT, default 65535, SHALL set the maximum RUN cycles before the watchdog fires.
REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 req  in  NREQ  level request per requester, held high until that requester's done pulse.
REQ-008 cfg_src, cfg_dst  in  NREQ*AW  packed per-requester source/destination base addresses.
REQ-009 cfg_rows, cfg_cols  in  NREQ*DW  packed per-requester matrix dimensions.
REQ-010 eng_done  in  1  engine completion, one-cycle pulse.
REQ-011 eng_start  out  1  engine launch, one-cycle pulse.
REQ-012 eng_src, eng_dst  out  AW  and eng_rows, eng_cols  out  DW: registered job descriptor.
REQ-013 grant  out  NREQ  one-hot owner of the engine, or all-zero.
REQ-014 done  out  NREQ  one-cycle completion pulse to the owner.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err  out  1  sticky protocol/watchdog error flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RUN, RELEASE.
REQ-018 In IDLE with any req bit high, the arbiter SHALL pick a round-robin winner starting from ptr, latch the winner's cfg fields into eng_*, and go to ISSUE; with req all-zero it SHALL stay in IDLE.
REQ-019 grant SHALL be the registered one-hot winner, asserted from ISSUE through RELEASE inclusive and zero in IDLE.
REQ-020 eng_start SHALL be high only in ISSUE (exactly one cycle); the next state SHALL be RUN.
REQ-021 eng_* SHALL stay stable from ISSUE through RELEASE, and cfg changes during that window SHALL be ignored.
REQ-022 In RUN, eng_done SHALL move the FSM to RELEASE; otherwise it SHALL remain in RUN.
REQ-023 In RELEASE, done[winner] SHALL be high for one cycle, ptr SHALL become (winner+1) mod NREQ, and the next state SHALL be IDLE.
REQ-024 Latency: req rising in IDLE at cycle t SHALL give grant and eng_start at t+1; eng_done at cycle u SHALL give done at u+1 and grant=0 at u+2.
REQ-025 A requester dropping req during ISSUE or RUN SHALL NOT abort the job, and done SHALL still pulse.
REQ-026 A requester still holding req in IDLE after its done SHALL be arbitrated normally at lowest priority.
REQ-027 eng_done arriving in IDLE, ISSUE or RELEASE SHALL be ignored for sequencing and SHALL set err.
REQ-028 A RUN cycle counter SHALL clear on entry to RUN; if it reaches TIMEOUT without eng_done, err SHALL set and the FSM SHALL go to RELEASE, with done pulsed so the requester is not deadlocked.
REQ-029 ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-030 While reset is high at a clock edge: state=IDLE, ptr=0, grant=0, done=0, eng_start=0, eng_*=0, err=0, busy=0, watchdog counter=0.
REQ-031 Reset mid-job SHALL abandon the job without a done pulse, and err SHALL be cleared.

Structure
REQ-032 The state enum, NREQ, AW, DW and the requester index constants SHALL live in shared package llm_ctrl_pkg.
REQ-033 Round-robin winner selection (req, ptr -> one-hot) SHALL be a combinational sub-module rr_pick.

Verification
REQ-034 Single request: req=4'b0100, cfg_src[2]=0x1200 -> at t+1 grant=4'b0100, eng_start=1, eng_src=0x1200; eng_done at t+10 -> done=4'b0100 at t+11, grant=0 at t+12.
REQ-035 Fairness: req=4'b1111 held through four jobs -> grants in order 0001, 0010, 0100, 1000, then 0001 again.
REQ-036 Stale request: requester 0 keeps req high after its done while requester 3 also requests -> the next grant goes to 1000.
REQ-037 Spurious completion: eng_done pulsed in IDLE -> err=1 with no grant change; err stays high until reset.
REQ-038 Watchdog: TIMEOUT=8 and no eng_done -> err=1, and done pulses 9 cycles after eng_start.
REQ-039 Reset mid-job: reset in RUN -> the next cycle shows busy=0, grant=0 and no done pulse.
